// File: rtl/vgrey4_tracker_pkg.sv
// Shared types for the Gray-code position tracker: FSM encoding and sample width.
package vgrey4_tracker_pkg;

    localparam int GREY_W = 4;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

endpackage

// File: rtl/vgrey4_tracker_if.sv
// Sample input and tracker result bundle; master drives samples, slave is the tracker.
interface vgrey4_tracker_if
    import vgrey4_tracker_pkg::*;
#(
    parameter int POS_W = 8
);
    logic [GREY_W-1:0] grey;
    logic              ce;
    logic [GREY_W-1:0] bin;
    logic [POS_W-1:0]  pos;
    logic              step;
    logic              dir;
    logic              err;
    logic              locked;
    logic              TC;

    modport master (
        output grey, ce,
        input  bin, pos, step, dir, err, locked, TC
    );

    modport slave (
        input  grey, ce,
        output bin, pos, step, dir, err, locked, TC
    );
endinterface

// File: rtl/vgrey4_tracker_grey4_to_bin.sv
// Combinational Gray-to-binary decode; each binary bit is the XOR of all Gray bits at or above it.
module grey4_to_bin
    import vgrey4_tracker_pkg::*;
(
    input  logic [GREY_W-1:0] g,
    output logic [GREY_W-1:0] b
);
    always_comb begin
        b = '0;
        for (int i = 0; i < GREY_W; i++) begin
            b[i] = ^(g >> i);
        end
    end
endmodule

// File: rtl/vgrey4_tracker.sv
// Tracks position from a sampled 4-bit Gray counter; two-cycle latency, all outputs registered.
// No backpressure: ce qualifies each sample and an unqualified cycle is simply ignored.
module vgrey4_tracker
    import vgrey4_tracker_pkg::*;
#(
    parameter int POS_W = 8
) (
    input  logic             clk,
    input  logic             R,
    vgrey4_tracker_if.slave  bus
);
    logic [GREY_W-1:0] grey_q;
    logic              ce_q;
    logic [GREY_W-1:0] b;

    state_t            state_q, state_d;
    logic [GREY_W-1:0] bin_q, bin_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic              dir_q, dir_d;
    logic              step_q, step_d;
    logic              err_q, err_d;
    logic              tc_q, tc_d;

    grey4_to_bin u_dec (
        .g (grey_q),
        .b (b)
    );

    always_ff @(posedge clk) begin
        if (R) begin
            grey_q  <= '0;
            ce_q    <= 1'b0;
            state_q <= UNLOCKED;
            bin_q   <= '0;
            pos_q   <= '0;
            dir_q   <= 1'b1;
            step_q  <= 1'b0;
            err_q   <= 1'b0;
            tc_q    <= 1'b0;
        end else begin
            grey_q  <= bus.grey;
            ce_q    <= bus.ce;
            state_q <= state_d;
            bin_q   <= bin_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            err_q   <= err_d;
            tc_q    <= tc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        step_d  = 1'b0;
        err_d   = 1'b0;
        tc_d    = 1'b0;
        if (ce_q) begin
            case (state_q)
                UNLOCKED: begin
                    bin_d   = b;
                    state_d = LOCKED;
                end
                LOCKED: begin
                    // Code wrap 15<->0 falls out of the 4-bit +/-1 arithmetic.
                    if (b == bin_q) begin
                        state_d = LOCKED;
                    end else if (b == bin_q + GREY_W'(1)) begin
                        bin_d  = b;
                        pos_d  = pos_q + POS_W'(1);
                        dir_d  = 1'b1;
                        step_d = 1'b1;
                        tc_d   = (pos_q == '1);
                    end else if (b == bin_q - GREY_W'(1)) begin
                        bin_d  = b;
                        pos_d  = pos_q - POS_W'(1);
                        dir_d  = 1'b0;
                        step_d = 1'b1;
                        tc_d   = (pos_q == '0);
                    end else begin
                        bin_d   = b;
                        err_d   = 1'b1;
                        state_d = UNLOCKED;
                    end
                end
                default: state_d = UNLOCKED;
            endcase
        end
    end

    assign bus.bin    = bin_q;
    assign bus.pos    = pos_q;
    assign bus.dir    = dir_q;
    assign bus.step   = step_q;
    assign bus.err    = err_q;
    assign bus.TC     = tc_q;
    assign bus.locked = (state_q == LOCKED);
endmodule

// File: tb/tb_vgrey4_tracker.sv
// Directed and random stimulus for vgrey4_tracker against a cycle-level reference model.
module tb_vgrey4_tracker;
    localparam int POS_W = 8;
    localparam int PMAX  = (1 << POS_W) - 1;

    logic clk = 1'b0;
    logic R;

    vgrey4_tracker_if #(.POS_W(POS_W)) bus ();

    vgrey4_tracker #(.POS_W(POS_W)) dut (
        .clk (clk),
        .R   (R),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int m_bin, m_pos, m_dir, m_locked, m_step, m_err, m_tc;
    int pend_g, pend_ce;
    int tc_count, step_count, err_count;
    string phase;

    function automatic int g2b(int g);
        int acc = 0;
        int b   = 0;
        for (int k = 3; k >= 0; k--) begin
            acc = acc ^ ((g >> k) & 1);
            b   = b | (acc << k);
        end
        return b;
    endfunction

    function automatic int b2g(int b);
        return (b ^ (b >> 1)) & 15;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_bin = 0; m_pos = 0; m_dir = 1; m_locked = 0;
        m_step = 0; m_err = 0; m_tc = 0;
        pend_g = 0; pend_ce = 0;
    endtask

    task automatic model_apply();
        int b, d;
        m_step = 0; m_err = 0; m_tc = 0;
        if (pend_ce != 0) begin
            b = g2b(pend_g);
            if (m_locked == 0) begin
                m_bin = b;
                m_locked = 1;
            end else begin
                d = (b - m_bin) & 15;
                if (d == 1) begin
                    m_step = 1; m_dir = 1;
                    m_tc = (m_pos == PMAX) ? 1 : 0;
                    m_pos = (m_pos + 1) & PMAX;
                    m_bin = b;
                end else if (d == 15) begin
                    m_step = 1; m_dir = 0;
                    m_tc = (m_pos == 0) ? 1 : 0;
                    m_pos = (m_pos - 1) & PMAX;
                    m_bin = b;
                end else if (d != 0) begin
                    m_err = 1;
                    m_bin = b;
                    m_locked = 0;
                end
            end
        end
    endtask

    task automatic tick(input int g, input int c, input int r);
        bus.grey = 4'(g);
        bus.ce   = c[0];
        R        = r[0];
        @(posedge clk);
        #1;
        if (r != 0) begin
            model_reset();
        end else begin
            model_apply();
            pend_g  = g;
            pend_ce = c;
        end
        if (bus.TC)   tc_count++;
        if (bus.step) step_count++;
        if (bus.err)  err_count++;
        chk({phase, ".bin"},    int'(bus.bin),    m_bin);
        chk({phase, ".pos"},    int'(bus.pos),    m_pos);
        chk({phase, ".dir"},    int'(bus.dir),    m_dir);
        chk({phase, ".step"},   int'(bus.step),   m_step);
        chk({phase, ".err"},    int'(bus.err),    m_err);
        chk({phase, ".TC"},     int'(bus.TC),     m_tc);
        chk({phase, ".locked"}, int'(bus.locked), m_locked);
    endtask

    initial begin
        int cur, sel, r;
        bus.grey = '0;
        bus.ce   = 1'b0;
        R        = 1'b1;
        model_reset();
        tc_count = 0; step_count = 0; err_count = 0;

        phase = "reset";
        tick(0, 0, 1);
        tick(5, 1, 1);

        phase = "up_seq";
        step_count = 0;
        tick(0, 1, 0); tick(1, 1, 0); tick(3, 1, 0); tick(2, 1, 0); tick(6, 1, 0);
        tick(6, 0, 0);
        chk("up_seq.steps", step_count, 4);
        chk("up_seq.pos_final", int'(bus.pos), 4);
        chk("up_seq.bin_final", int'(bus.bin), 4);
        chk("up_seq.dir_final", int'(bus.dir), 1);

        phase = "down_wrap";
        tick(0, 0, 1);
        tick(0, 1, 0); tick(8, 1, 0); tick(8, 0, 0);
        chk("down_wrap.pos_ff", int'(bus.pos), 255);
        chk("down_wrap.tc", int'(bus.TC), 1);
        chk("down_wrap.dir0", int'(bus.dir), 0);
        chk("down_wrap.bin15", int'(bus.bin), 15);

        phase = "up_256";
        tick(0, 0, 1);
        tick(0, 1, 0);
        tc_count = 0; step_count = 0;
        for (int i = 1; i <= 256; i++) tick(b2g(i & 15), 1, 0);
        tick(0, 0, 0);
        chk("up_256.tc_count", tc_count, 1);
        chk("up_256.steps", step_count, 256);
        chk("up_256.pos_zero", int'(bus.pos), 0);

        phase = "jump_err";
        tick(0, 0, 1);
        tick(3, 1, 0); tick(3, 0, 0);
        tick(15, 1, 0); tick(15, 0, 0);
        chk("jump_err.err", int'(bus.err), 1);
        chk("jump_err.unlocked", int'(bus.locked), 0);
        chk("jump_err.pos", int'(bus.pos), 0);
        step_count = 0;
        tick(15, 1, 0); tick(15, 0, 0);
        chk("jump_err.relock", int'(bus.locked), 1);
        chk("jump_err.no_step", step_count, 0);
        chk("jump_err.bin10", int'(bus.bin), 10);

        phase = "ce_hold";
        step_count = 0; err_count = 0; tc_count = 0;
        for (int i = 0; i < 6; i++) tick(15, i % 2, 0);
        for (int i = 0; i < 4; i++) tick(b2g(i * 5), 0, 0);
        chk("ce_hold.pulses", step_count + err_count + tc_count, 0);
        chk("ce_hold.bin", int'(bus.bin), 10);
        chk("ce_hold.pos", int'(bus.pos), 0);

        phase = "mid_reset";
        tick(0, 0, 1);
        tick(0, 1, 0);
        for (int i = 1; i <= 5; i++) tick(b2g(i), 1, 0);
        tick(b2g(6), 1, 0);
        chk("mid_reset.pos5", int'(bus.pos), 5);
        tick(b2g(7), 1, 1);
        chk("mid_reset.pos0", int'(bus.pos), 0);
        chk("mid_reset.dir1", int'(bus.dir), 1);
        chk("mid_reset.unlocked", int'(bus.locked), 0);
        step_count = 0;
        tick(b2g(9), 1, 0); tick(b2g(9), 0, 0);
        chk("mid_reset.relock", int'(bus.locked), 1);
        chk("mid_reset.no_step", step_count, 0);
        chk("mid_reset.bin9", int'(bus.bin), 9);

        phase = "random";
        tick(0, 0, 1);
        cur = 0;
        for (int i = 0; i < 1500; i++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 40)      cur = (cur + 1) & 15;
            else if (sel < 75) cur = (cur - 1) & 15;
            else if (sel < 90) cur = cur;
            else               cur = int'($urandom_range(0, 15));
            r = ($urandom_range(0, 199) == 0) ? 1 : 0;
            tick(b2g(cur), ($urandom_range(0, 3) != 0) ? 1 : 0, r);
        end
        tick(0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
